// File: rtl/lsu_mem_initiator_pkg.sv
// Shared definitions for the load/store memory initiator: access-type
// encodings, FSM state encoding and an alignment helper.
package lsu_mem_initiator_pkg;

    localparam logic [2:0] DM_W  = 3'd0;
    localparam logic [2:0] DM_H  = 3'd1;
    localparam logic [2:0] DM_HU = 3'd2;
    localparam logic [2:0] DM_B  = 3'd3;
    localparam logic [2:0] DM_BU = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    // Codes 5..7 are not access types.
    function automatic logic op_is_valid(input logic [2:0] op);
        return (op <= DM_BU);
    endfunction

    // True when the low address bits are not aligned to the access size.
    function automatic logic op_is_misaligned(input logic [2:0] op, input logic [1:0] lo);
        return (((op == DM_H) || (op == DM_HU)) && lo[0]) || ((op == DM_W) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_mem_initiator_lane_align.sv
// Combinational byte/halfword lane logic: extracts and extends load data
// from a memory word, and merges sub-word store data into an old word.
module lsu_lane_align
    import lsu_mem_initiator_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  op,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword lanes out of the word
    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    end

    // Sign- or zero-extend the selected lane according to the access type
    always_comb begin
        load_data = 32'd0;
        case (op)
            DM_W:    load_data = word;
            DM_H:    load_data = {{16{half_sel[15]}}, half_sel};
            DM_HU:   load_data = {16'd0, half_sel};
            DM_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            DM_BU:   load_data = {24'd0, byte_sel};
            default: load_data = 32'd0;
        endcase
    end

    // Overwrite only the addressed lane, keeping all other bytes of the old word
    always_comb begin
        merged = word;
        case (op)
            DM_W: merged = wdata;
            DM_H, DM_HU: begin
                if (addr_lo[1]) merged[31:16] = wdata[15:0];
                else            merged[15:0]  = wdata[15:0];
            end
            DM_B, DM_BU: begin
                case (addr_lo)
                    2'd0: merged[7:0]   = wdata[7:0];
                    2'd1: merged[15:8]  = wdata[7:0];
                    2'd2: merged[23:16] = wdata[7:0];
                    2'd3: merged[31:24] = wdata[7:0];
                    default: merged = word;
                endcase
            end
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the CPU MEM stage and a word-wide memory
// port with req/ack handshake. Sub-word stores are done as read-modify-write.
// Optional build macro LSU_MISALIGN_EN: misaligned h/hu/w accesses are
// rejected with an error instead of being force-aligned.
module lsu_mem_initiator
    import lsu_mem_initiator_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    lsu_state_t        state, state_n;
    logic              lat_we, lat_we_n;
    logic [2:0]        lat_op, lat_op_n;
    logic [1:0]        lat_lo, lat_lo_n;
    logic [31:0]       lat_wdata, lat_wdata_n;
    logic [7:0]        wait_cnt, wait_cnt_n;
    logic              mem_req_n, mem_we_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [31:0]       mem_wdata_n, resp_rdata_n;
    logic              resp_err_n;
    logic [31:0]       load_data, merged_word;
    logic              misaligned, timed_out;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
    assign req_ready      = (state == ST_IDLE);
    assign resp_valid     = (state == ST_RESP);
    assign timed_out      = (wait_cnt == 8'(TIMEOUT - 1));

    lsu_lane_align u_lane_align (
        .word      (mem_rdata),
        .wdata     (lat_wdata),
        .addr_lo   (lat_lo),
        .op        (lat_op),
        .load_data (load_data),
        .merged    (merged_word)
    );

    // Decide whether alignment alone rejects the incoming request
    always_comb begin
`ifdef LSU_MISALIGN_EN
        misaligned = op_is_misaligned(req_op, req_addr[1:0]);
`else
        misaligned = 1'b0;
`endif
    end

    // State register; reset aborts any transaction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    // Next state plus next values of the request latch, memory request and response registers
    always_comb begin
        state_n      = state;
        lat_we_n     = lat_we;
        lat_op_n     = lat_op;
        lat_lo_n     = lat_lo;
        lat_wdata_n  = lat_wdata;
        wait_cnt_n   = wait_cnt;
        mem_req_n    = mem_req;
        mem_we_n     = mem_we;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        resp_rdata_n = resp_rdata;
        resp_err_n   = resp_err;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    lat_we_n     = req_we;
                    lat_op_n     = req_op;
                    lat_lo_n     = req_addr[1:0];
                    lat_wdata_n  = req_wdata;
                    mem_addr_n   = req_addr[ADDR_W+1:2];
                    wait_cnt_n   = 8'd0;
                    resp_rdata_n = 32'd0;
                    resp_err_n   = 1'b0;
                    if (!op_is_valid(req_op) || misaligned ||
                        (req_we && ((req_op == DM_HU) || (req_op == DM_BU)))) begin
                        state_n    = ST_RESP;
                        resp_err_n = 1'b1;
                    end else if (req_we && (req_op == DM_W)) begin
                        state_n     = ST_WR;
                        mem_req_n   = 1'b1;
                        mem_we_n    = 1'b1;
                        mem_wdata_n = req_wdata;
                    end else begin
                        state_n   = ST_RD;
                        mem_req_n = 1'b1;
                        mem_we_n  = 1'b0;
                    end
                end
            end
            ST_RD: begin
                if (mem_ack) begin
                    wait_cnt_n = 8'd0;
                    if (lat_we) begin
                        state_n     = ST_WR;
                        mem_we_n    = 1'b1;
                        mem_wdata_n = merged_word;
                    end else begin
                        state_n      = ST_RESP;
                        mem_req_n    = 1'b0;
                        resp_rdata_n = load_data;
                    end
                end else if (timed_out) begin
                    state_n    = ST_RESP;
                    mem_req_n  = 1'b0;
                    resp_err_n = 1'b1;
                end else begin
                    wait_cnt_n = wait_cnt + 8'd1;
                end
            end
            ST_WR: begin
                if (mem_ack) begin
                    state_n   = ST_RESP;
                    mem_req_n = 1'b0;
                    mem_we_n  = 1'b0;
                end else if (timed_out) begin
                    state_n    = ST_RESP;
                    mem_req_n  = 1'b0;
                    mem_we_n   = 1'b0;
                    resp_err_n = 1'b1;
                end else begin
                    wait_cnt_n = wait_cnt + 8'd1;
                end
            end
            ST_RESP: begin
                state_n      = ST_IDLE;
                mem_we_n     = 1'b0;
                resp_rdata_n = 32'd0;
                resp_err_n   = 1'b0;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Registered datapath: request latch, timeout counter, memory request and response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_we     <= 1'b0;
            lat_op     <= 3'd0;
            lat_lo     <= 2'd0;
            lat_wdata  <= 32'd0;
            wait_cnt   <= 8'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            lat_we     <= lat_we_n;
            lat_op     <= lat_op_n;
            lat_lo     <= lat_lo_n;
            lat_wdata  <= lat_wdata_n;
            wait_cnt   <= wait_cnt_n;
            mem_req    <= mem_req_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            resp_rdata <= resp_rdata_n;
            resp_err   <= resp_err_n;
        end
    end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator between the CPU MEM stage and a word-wide data memory port with a req/ack handshake.
- Takes one byte, halfword or word access and converts it to word reads and writes on the memory side.
- Sub-word stores use read-modify-write. Loads are sign- or zero-extended.
- Returns one response pulse per accepted request. A timeout guards against a memory that never acknowledges.

Parameters:
- ADDR_W, 10: word-address width on the memory side; mem_addr = req_addr[ADDR_W+1:2].
- TIMEOUT, 255: maximum cycles to wait for mem_ack before aborting with an error; valid range 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req_valid  in  1  CPU request valid
- req_ready  out  1  initiator can accept a request
- req_we  in  1  1 = store, 0 = load
- req_op  in  3  access type: DM_w/DM_h/DM_hu/DM_b/DM_bu
- req_addr  in  32  byte address
- req_wdata  in  32  store data; the low bits are used for sub-word stores
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  qualifies resp_valid: misalign, timeout or invalid op
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  full write word
- mem_rdata  in  32  read word, valid when mem_ack=1
- mem_ack  in  1  memory handshake completion

Behaviour:
- Reset values: all outputs 0 except req_ready=1; FSM = IDLE; the request latch and the wait counter are cleared.
- Reset asserted mid-transaction aborts it immediately. No response is issued and mem_req drops.
- FSM states: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready, latch we/op/addr/wdata.
  - Invalid op, or a store with op hu/bu: go to RESP with err=1; no memory access.
  - Load: go to RD.
  - Word store: go to WR, with mem_wdata = wdata.
  - Byte or half store: go to RD (read-modify-write).
- RD:
  - Drive mem_req=1, mem_we=0 and mem_addr.
  - On mem_ack, capture mem_rdata.
  - For a load: extend the captured data and go to RESP.
  - For a read-modify-write: merge WD[7:0] into byte lane addr[1:0], or WD[15:0] into half lane addr[1]; all other lanes are kept. Go to WR.
- WR: drive mem_req=1, mem_we=1 and the merged word; on mem_ack go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in every state except IDLE.
- Sub-word extraction:
  - Byte lane n = bits [8n+7:8n].
  - Half lane k = bits [16k+15:16k].
  - h/b sign-extend; hu/bu zero-extend.
- The request signals (mem_req, mem_we, mem_addr, mem_wdata) are registered and must stay stable while mem_req=1 and ack has not arrived.
- mem_ack is ignored outside RD and WR.
- Timeout:
  - An 8-bit counter clears on entry to RD or WR and increments on each cycle without ack.
  - When it reaches TIMEOUT, drop mem_req and go to RESP with err=1.
  - A timeout in RD of a read-modify-write skips the write.
- Minimum latency with a same-cycle ack:
  - load or word store: accept at cycle 0, resp_valid at cycle 2;
  - sub-word store: resp_valid at cycle 3.
- Back-to-back: a new request may be accepted the cycle after RESP.

Optional Feature:
- LSU_MISALIGN_EN defined:
  - h/hu with addr[0]=1, or w with addr[1:0]≠0, goes straight to RESP with err=1.
  - No memory access is made.
- LSU_MISALIGN_EN undefined:
  - The low address bits below the access size are ignored (forced alignment).
  - These accesses never return an error.

Decomposition:
- Shared constants file holds the DM_op encodings (DM_w=0, DM_h=1, DM_hu=2, DM_b=3, DM_bu=4; 5–7 invalid) and the FSM state encodings.
- Sub-module lsu_lane_align (combinational) provides:
  - load extraction/extension from (word, addr[1:0], op);
  - store merge from (old word, wdata, addr[1:0], op).
- The FSM and the timeout counter stay in the top level.

Test Plan:
- Word store then load:
  - store addr=0x10, wdata=0xDEADBEEF, ack after 2 cycles: one write at mem_addr=4, resp_err=0.
  - load w from 0x10: resp_rdata=0xDEADBEEF.
- Byte store read-modify-write: memory word@4=0x11223344; sb addr=0x12, wdata=0xAB → one read then one write of 0x11AB3344.
- Signed vs unsigned loads: word=0x80FF7F01.
  - lb addr 2 → 0xFFFFFFFF; lbu addr 3 → 0x00000080.
  - lh addr 2 → 0xFFFF80FF; lhu addr 0 → 0x00007F01.
- Timeout: TIMEOUT=4, ack held 0 → resp_valid with resp_err=1 after 4 wait cycles; mem_req deasserted; no write for an sb.
- Reset mid-WR: assert reset while mem_req=1 → mem_req=0 and req_ready=1 immediately; no resp_valid.
- Misalignment, lw addr=0x13:
  - with LSU_MISALIGN_EN: err=1, no mem_req;
  - without it: reads word 4, err=0.
